// File: rtl/flop_pkg.sv
// Shared constants and buffer entry type for the FP multiplier post-processing stage.
package flop_pkg;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;

  // Bit positions inside the 3-bit flags / sticky vectors
  localparam int unsigned FLAG_INV = 0;
  localparam int unsigned FLAG_OVF = 1;
  localparam int unsigned FLAG_UNF = 2;
  localparam int unsigned FLAG_W   = 3;

  // One buffered result: final product word plus its exception flags
  typedef struct packed {
    logic [31:0]       result;
    logic [FLAG_W-1:0] flags;
  } entry_t;

endpackage

// File: rtl/flop_classify.sv
// Combinational IEEE-754 single operand classifier; denormals count as zero (flush-to-zero).
module flop_classify
  import flop_pkg::*;
(
  input  logic [31:0] op_i,
  output logic        is_zero_o,
  output logic        is_inf_o,
  output logic        is_nan_o
);

  logic [7:0]  exp_w;
  logic [22:0] man_w;

  assign exp_w = op_i[30:23];
  assign man_w = op_i[22:0];

  // Classify from exponent/mantissa fields
  always_comb begin
    is_zero_o = (exp_w == '0);
    is_inf_o  = (exp_w == 8'(EXP_MAX)) && (man_w == '0);
    is_nan_o  = (exp_w == 8'(EXP_MAX)) && (man_w != '0);
  end

endmodule

// File: rtl/flop_mul_post.sv
// Post-processing for a single-precision multiplier: special-case/exception
// resolution at accept time, a 2-entry result FIFO and sticky flag accumulation.
module flop_mul_post
  import flop_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] raw_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags,
  output logic [2:0]  sticky,
  input  logic        sticky_clr
);

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  flop_classify u_cls_a (
    .op_i      (op_a),
    .is_zero_o (a_zero),
    .is_inf_o  (a_inf),
    .is_nan_o  (a_nan)
  );

  flop_classify u_cls_b (
    .op_i      (op_b),
    .is_zero_o (b_zero),
    .is_inf_o  (b_inf),
    .is_nan_o  (b_nan)
  );

  logic              sign_w;
  logic signed [9:0] w_exp;
  logic signed [9:0] e_exp;
  logic [7:0]        carry_diff;
  logic              carry_w;
  entry_t            new_entry;

  assign sign_w = op_a[31] ^ op_b[31];
  assign w_exp  = $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]})
                - $signed(10'(EXP_BIAS));
  // The multiplier's own exponent tells us whether it renormalised; when it has
  // already saturated or flushed the difference is not 0/1, and then only the
  // uncarried exponent is trusted (it lands in the same overflow/underflow band).
  assign carry_diff = raw_prod[30:23] - w_exp[7:0];
  assign carry_w    = (carry_diff == 8'd1);
  assign e_exp      = w_exp + $signed({9'b0, carry_w});

  // Resolve special cases in priority order into the entry to be buffered
  always_comb begin
    new_entry = '0;
    if (a_nan || b_nan) begin
      new_entry.result          = QNAN;
      new_entry.flags[FLAG_INV] = 1'b1;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      new_entry.result          = QNAN;
      new_entry.flags[FLAG_INV] = 1'b1;
    end else if (a_inf || b_inf) begin
      new_entry.result = {sign_w, 8'hFF, 23'b0};
    end else if (a_zero || b_zero) begin
      new_entry.result = {sign_w, 31'b0};
    end else if (e_exp >= $signed(10'(EXP_MAX))) begin
      new_entry.result          = {sign_w, 8'hFF, 23'b0};
      new_entry.flags[FLAG_OVF] = 1'b1;
    end else if (e_exp <= 10'sd0) begin
      new_entry.result          = {sign_w, 31'b0};
      new_entry.flags[FLAG_UNF] = 1'b1;
    end else begin
      new_entry.result = raw_prod;
    end
  end

  entry_t      mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [2:0]  sticky_q, sticky_d;
  logic        push_w, pop_w;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign result    = mem_q[rd_ptr_q].result;
  assign flags     = mem_q[rd_ptr_q].flags;
  assign sticky    = sticky_q;

  assign push_w = in_valid && in_ready;
  assign pop_w  = out_valid && out_ready;

  // Next-state for pointers, occupancy and sticky flags (set wins over clear)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_clr ? 3'b000 : sticky_q;
    if (push_w) begin
      wr_ptr_d = ~wr_ptr_q;
      sticky_d = sticky_d | new_entry.flags;
    end
    if (pop_w) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push_w && !pop_w) begin
      count_d = count_q + 2'd1;
    end else if (pop_w && !push_w) begin
      count_d = count_q - 2'd1;
    end
  end

  // FIFO storage and state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      if (push_w) begin
        mem_q[wr_ptr_q] <= new_entry;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_flop_mul_post.sv
// Directed self-checking bench for flop_mul_post.
module tb_flop_mul_post;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b, raw_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;
  logic [2:0]  sticky;
  logic        sticky_clr;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  flop_mul_post dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .raw_prod   (raw_prod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags),
    .sticky     (sticky),
    .sticky_clr (sticky_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    raw_prod = r;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    raw_prod = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sticky_clr = 1'b0; out_ready = 1'b0;
    idle();
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'b0, flags}, 32'd0);
    chk("rst_sticky", {29'b0, sticky}, 32'd0);
    rst = 1'b0;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 2.0 * 3.0 = 6.0, visible exactly one cycle after accept
    out_ready = 1'b1;
    drive(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    chk("normal_pre_valid", {31'b0, out_valid}, 32'd0);
    step(); idle();
    chk("normal_valid", {31'b0, out_valid}, 32'd1);
    chk("normal_result", result, 32'h40C0_0000);
    chk("normal_flags", {29'b0, flags}, 32'd0);
    step();
    chk("normal_popped", {31'b0, out_valid}, 32'd0);

    // overflow
    drive(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
    step(); idle();
    chk("ovf_result", result, 32'h7F80_0000);
    chk("ovf_flags", {29'b0, flags}, 32'd2);
    chk("ovf_sticky", {29'b0, sticky}, 32'd2);
    step();
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("clr_sticky", {29'b0, sticky}, 32'd0);

    // Inf * 0 -> invalid
    drive(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    step(); idle();
    chk("infzero_result", result, 32'h7FC0_0000);
    chk("infzero_flags", {29'b0, flags}, 32'd1);
    step();

    // NaN * 1.0 -> invalid, canonical NaN
    drive(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001);
    step(); idle();
    chk("nan_result", result, 32'h7FC0_0000);
    chk("nan_flags", {29'b0, flags}, 32'd1);
    step();

    // underflow with negative sign
    drive(32'h8080_0000, 32'h0080_0000, 32'h8000_0000);
    step(); idle();
    chk("unf_result", result, 32'h8000_0000);
    chk("unf_flags", {29'b0, flags}, 32'd4);
    chk("unf_sticky", {29'b0, sticky}, 32'd5);
    step();

    // 1.5 * 1.5 = 2.25, multiplier renormalised (carry path)
    drive(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    step(); idle();
    chk("carry_result", result, 32'h4010_0000);
    chk("carry_flags", {29'b0, flags}, 32'd0);
    step();

    // negative denormal * 1.0 -> signed zero, no flag
    drive(32'h8040_0000, 32'h3F80_0000, 32'h8040_0000);
    step(); idle();
    chk("ftz_result", result, 32'h8000_0000);
    chk("ftz_flags", {29'b0, flags}, 32'd0);
    step();

    // -Inf * 2.0 -> -Inf, no flag
    drive(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    step(); idle();
    chk("inf_result", result, 32'hFF80_0000);
    chk("inf_flags", {29'b0, flags}, 32'd0);
    chk("inf_sticky_kept", {29'b0, sticky}, 32'd5);
    step();

    // backpressure: three offered, two accepted, FIFO order on drain
    out_ready = 1'b0;
    drive(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    step();
    chk("bp_ready_1", {31'b0, in_ready}, 32'd1);
    drive(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    step();
    chk("bp_ready_full", {31'b0, in_ready}, 32'd0);
    drive(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    step();
    chk("bp_ready_still_full", {31'b0, in_ready}, 32'd0);
    chk("bp_head_first", result, 32'h4010_0000);
    idle();
    out_ready = 1'b1;
    step();
    chk("bp_head_second", result, 32'h40C0_0000);
    chk("bp_ready_again", {31'b0, in_ready}, 32'd1);
    // simultaneous push and pop keeps occupancy at one
    drive(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    step(); idle();
    chk("pp_valid", {31'b0, out_valid}, 32'd1);
    chk("pp_result", result, 32'h4080_0000);
    chk("pp_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("pp_drained", {31'b0, out_valid}, 32'd0);

    // reset with two entries held and sticky = 101; in_valid ignored on that edge
    out_ready = 1'b0;
    drive(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    step();
    drive(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    step();
    chk("hold_full", {31'b0, in_ready}, 32'd0);
    chk("hold_sticky", {29'b0, sticky}, 32'd5);
    rst = 1'b1;
    drive(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
    step();
    rst = 1'b0; idle();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_sticky", {29'b0, sticky}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);

    // sticky_clr coincident with an overflow accept: set wins
    out_ready = 1'b1;
    drive(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001);
    step();
    chk("pre_clr_sticky", {29'b0, sticky}, 32'd1);
    sticky_clr = 1'b1;
    drive(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
    step();
    sticky_clr = 1'b0; idle();
    chk("clr_set_sticky", {29'b0, sticky}, 32'd2);
    chk("clr_set_result", result, 32'h7F80_0000);
    chk("clr_set_flags", {29'b0, flags}, 32'd2);
    step();
    chk("final_empty", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
